// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: memory request handshake between
// the control sequencer (master) and the memory (slave).
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/execute/mem/wb control FSM.
// MEM_TIMEOUT_EN: fault after TIMEOUT_CYCLES of memory stall.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [3:0]  HALT_OPCODE    = 4'b1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  multicycle_sequencer_if.master mem,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic [2:0] alu_op,
  output logic [2:0] state,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_FAULT   = 3'd7
  } state_e;

  state_e state_q, state_d;

  logic is_rtype;
  logic is_load;
  logic is_store;
  logic is_branch;
  logic mem_req_c;
  logic mem_we_c;
  logic timed_out;

  assign is_rtype  = (opcode[3:2] == 2'b00);
  assign is_load   = (opcode == 4'b0100);
  assign is_store  = (opcode == 4'b0101);
  assign is_branch = (opcode == 4'b0110);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_q, wait_d;
  logic [7:0] wait_inc;

  assign wait_inc  = wait_q + 8'd1;
  assign timed_out = (wait_inc == TO_LIM);

  // Counter restarts whenever the FSM leaves or enters a wait state.
  always_comb begin
    wait_d = 8'd0;
    if (mem_req_c && !mem.mem_ready && state_d == state_q)
      wait_d = wait_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= 8'd0;
    else        wait_q <= wait_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 3'b000;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_c = 1'b1;
        ir_write  = mem.mem_ready;
        pc_write  = mem.mem_ready;
        if (mem.mem_ready) state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode == HALT_OPCODE): state_d = S_HALT;
          (opcode <= 4'b0110):     state_d = S_EXECUTE;
          default:                 state_d = S_FAULT;
        endcase
      end
      S_EXECUTE: begin
        unique case (1'b1)
          is_rtype: begin
            alu_op  = opcode[2:0];
            state_d = S_WB;
          end
          is_load, is_store: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          is_branch: begin
            alu_op   = 3'b001;
            pc_write = zero;
            pc_src   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_store;
        alu_src   = 1'b1;
        if (mem.mem_ready)
          state_d = is_load ? S_WB : S_FETCH;
        else if (timed_out)
          state_d = S_FAULT;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_load;
        state_d    = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: table, directed and random checks
// of the sequencer against a per-instruction cycle model.
module tb_multicycle_sequencer;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       ir_write, pc_write, pc_src, reg_write;
  logic       reg_dst, alu_src, mem_to_reg;
  logic [2:0] alu_op, state;
  logic       halted, fault;

  int checks = 0;
  int failures = 0;

  multicycle_sequencer_if mif ();

  multicycle_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .HALT_OPCODE(4'b1111)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .zero(zero),
    .mem(mif.master),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .reg_write(reg_write),
    .reg_dst(reg_dst),
    .alu_src(alu_src),
    .mem_to_reg(mem_to_reg),
    .alu_op(alu_op),
    .state(state),
    .halted(halted),
    .fault(fault)
  );

  always #5 clk = ~clk;

  logic [16:0] got;
  assign got = {state, mif.mem_req, mif.mem_we, ir_write,
                pc_write, pc_src, reg_write, reg_dst,
                alu_src, mem_to_reg, alu_op, halted, fault};

  typedef struct {
    logic        rdy;
    logic        z;
    logic [3:0]  op;
    logic [16:0] exp;
    string       name;
  } step_t;

  typedef struct {
    logic        rdy;
    logic [3:0]  op;
    logic [16:0] exp;
  } vec_t;

  step_t q[$];

  function automatic logic [16:0] ev(
    input logic [2:0] st, input logic req, input logic we,
    input logic irw, input logic pcw, input logic pcs,
    input logic rw, input logic rd, input logic asrc,
    input logic m2r, input logic [2:0] aop);
    return {st, req, we, irw, pcw, pcs, rw, rd, asrc, m2r,
            aop, st == 3'd6, st == 3'd7};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic check(input string nm, input logic [16:0] e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, e);
    end
  endtask

  task automatic push(input logic r, input logic z,
                      input logic [3:0] op, input logic [16:0] e,
                      input string nm);
    step_t s;
    s.rdy = r; s.z = z; s.op = op; s.exp = e; s.name = nm;
    q.push_back(s);
  endtask

  task automatic apply(input step_t s);
    @(negedge clk);
    mif.mem_ready = s.rdy;
    zero = s.z;
    opcode = s.op;
    #1;
    check(s.name, s.exp);
  endtask

  task automatic run_q();
    while (q.size() > 0) apply(q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_idle", ev(0,0,0,0,0,0,0,0,0,0,0));
  endtask

  // Expected cycle trace of one instruction from FETCH onward.
  task automatic gen(input logic [3:0] op, input int fw,
                     input int mw, input logic z);
    bit rt = (op <= 4'd3);
    bit ld = (op == 4'd4);
    bit sto = (op == 4'd5);
    bit br = (op == 4'd6);
    for (int i = 0; i < fw; i++)
      push(0, rb(), 4'($urandom),
           ev(1,1,0,0,0,0,0,0,0,0,0), "fetch_wait");
    push(1, rb(), 4'($urandom),
         ev(1,1,0,1,1,0,0,0,0,0,0), "fetch_done");
    push(rb(), rb(), op, ev(2,0,0,0,0,0,0,0,0,0,0), "decode");
    if (op == 4'hF) begin
      for (int i = 0; i < 20; i++)
        push(rb(), rb(), op,
             ev(6,0,0,0,0,0,0,0,0,0,0), "halt");
      return;
    end
    if (op > 4'd6) begin
      for (int i = 0; i < 5; i++)
        push(rb(), rb(), op,
             ev(7,0,0,0,0,0,0,0,0,0,0), "fault");
      return;
    end
    if (rt)
      push(rb(), rb(), op,
           ev(3,0,0,0,0,0,0,0,0,0,op[2:0]), "exec_r");
    else if (br)
      push(rb(), z, op,
           ev(3,0,0,0,z,1,0,0,0,0,3'b001), "exec_br");
    else
      push(rb(), rb(), op,
           ev(3,0,0,0,0,0,0,0,1,0,3'b000), "exec_mem");
    if (ld || sto) begin
      for (int i = 0; i < mw; i++)
        push(0, rb(), op,
             ev(4,1,sto,0,0,0,0,0,1,0,0), "mem_wait");
      push(1, rb(), op,
           ev(4,1,sto,0,0,0,0,0,1,0,0), "mem_done");
    end
    if (rt || ld)
      push(rb(), rb(), op,
           ev(5,0,0,0,0,0,1,rt,0,ld,0), "wb");
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 4'h0, ev(1,1,0,1,1,0,0,0,0,0,0)};
    tbl[1] = '{0, 4'h0, ev(2,0,0,0,0,0,0,0,0,0,0)};
    tbl[2] = '{1, 4'h0, ev(3,0,0,0,0,0,0,0,0,0,0)};
    tbl[3] = '{0, 4'h0, ev(5,0,0,0,0,0,1,1,0,0,0)};
    tbl[4] = '{0, 4'h3, ev(1,1,0,0,0,0,0,0,0,0,0)};
    tbl[5] = '{1, 4'h3, ev(1,1,0,1,1,0,0,0,0,0,0)};
    tbl[6] = '{1, 4'h3, ev(2,0,0,0,0,0,0,0,0,0,0)};
    tbl[7] = '{0, 4'h3, ev(3,0,0,0,0,0,0,0,0,0,3'b011)};
    tbl[8] = '{1, 4'h3, ev(5,0,0,0,0,0,1,1,0,0,0)};
    tbl[9] = '{1, 4'h1, ev(1,1,0,1,1,0,0,0,0,0,0)};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mif.mem_ready = tbl[i].rdy;
      zero = 1'b0;
      opcode = tbl[i].op;
      #1;
      check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    do_reset();
    gen(4'h4, 0, 3, 0);
    gen(4'h5, 1, 2, 0);
    gen(4'h6, 0, 0, 1);
    gen(4'h6, 0, 0, 0);
    gen(4'h2, 2, 0, 0);
    run_q();

    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 6));
      gen(op, $urandom_range(0, TO - 1),
          $urandom_range(0, TO - 1), rb());
      run_q();
    end

    do_reset();
    gen(4'hF, 1, 0, 0);
    run_q();

    do_reset();
    gen(4'h9, 0, 0, 0);
    run_q();

    do_reset();
    gen(4'(7 + $urandom_range(0, 6)), 0, 0, 0);
    run_q();

    do_reset();
    gen(4'h4, 0, 6, 0);
    for (int i = 0; i < 5; i++) apply(q.pop_front());
    q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem", ev(0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    #1;
    check("rst_hold", ev(0,0,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b1;
    gen(4'h1, 0, 0, 0);
    run_q();

`ifdef MEM_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < TO; i++)
      push(0, 0, 4'h0, ev(1,1,0,0,0,0,0,0,0,0,0), "to_wait");
    for (int i = 0; i < 3; i++)
      push(rb(), 0, 4'h0, ev(7,0,0,0,0,0,0,0,0,0,0), "to_fault");
    run_q();

    do_reset();
    gen(4'h0, TO - 1, 0, 0);
    gen(4'h4, 0, TO - 1, 0);
    for (int i = 0; i < TO - 1; i++)
      push(0, 0, 4'h5, ev(1,1,0,0,0,0,0,0,0,0,0), "to_f2");
    push(1, 0, 4'h5, ev(1,1,0,1,1,0,0,0,0,0,0), "to_f2d");
    push(0, 0, 4'h5, ev(2,0,0,0,0,0,0,0,0,0,0), "to_dec");
    push(0, 0, 4'h5, ev(3,0,0,0,0,0,0,0,1,0,0), "to_ex");
    for (int i = 0; i < TO; i++)
      push(0, 0, 4'h5, ev(4,1,1,0,0,0,0,0,1,0,0), "to_mw");
    push(1, 0, 4'h5, ev(7,0,0,0,0,0,0,0,0,0,0), "to_mf");
    run_q();
`else
    do_reset();
    gen(4'h4, 20, 20, 0);
    run_q();
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that steps the CPU through fetch, decode, execute, memory and writeback for the 4-bit ISA: ADD, SUB, AND, OR, LOAD, STORE, BRANCH, HALT.
- Sits between the instruction register and the datapath.
- Consumes the opcode and the ALU zero flag; drives PC/IR/register-file write enables, ALU op and the memory request handshake.
- Replaces single-cycle use of control_unit where memory has variable latency.

Parameters:
- TIMEOUT_CYCLES, 16, maximum wait cycles for mem_ready before FAULT (used only with MEM_TIMEOUT_EN).
- HALT_OPCODE, 4'b1111, opcode that stops the sequencer.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- opcode  input  4  IR[opcode] field, valid from DECODE onward.
- zero  input  1  ALU zero flag, sampled in EXECUTE.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request active.
- mem_we  output  1  request is a write (STORE).
- ir_write  output  1  load IR from memory read data.
- pc_write  output  1  update PC.
- pc_src  output  1  0 = PC+1, 1 = branch target.
- reg_write  output  1  register file write.
- reg_dst  output  1  1 = rd (R-type), 0 = rt (LOAD).
- alu_src  output  1  1 = immediate operand.
- mem_to_reg  output  1  writeback data from memory.
- alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR.
- state  output  3  current state, for debug.
- halted  output  1  sticky, in HALT.
- fault  output  1  sticky, in FAULT.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Reset (async, any time, including mid-request): state=IDLE. All outputs are 0 while in IDLE. An in-flight memory request is abandoned and mem_req drops immediately.
- IDLE → FETCH unconditionally on the first edge after rst_n rises.
- FETCH:
  - mem_req=1, mem_we=0.
  - ir_write, pc_write (pc_src=0) are Mealy outputs equal to mem_ready.
  - Stays in FETCH while mem_ready=0; → DECODE on mem_ready=1.
- DECODE: one cycle, all enables 0.
  - opcode 0000–0101 → EXECUTE.
  - 0110 (BRANCH) → EXECUTE.
  - HALT_OPCODE → HALT.
  - 0111–1110 (illegal) → FAULT.
- EXECUTE:
  - R-type (0000–0011): alu_op = opcode[2:0], alu_src=0; → WB.
  - LOAD/STORE: alu_op=000, alu_src=1; → MEM.
  - BRANCH: alu_op=001, alu_src=0; pc_write=zero, pc_src=1; → FETCH.
- MEM:
  - mem_req=1, mem_we=1 for STORE and 0 for LOAD, alu_op=000, alu_src=1.
  - Waits for mem_ready. LOAD → WB; STORE → FETCH.
- WB: reg_write=1 for one cycle; → FETCH.
  - R-type: reg_dst=1, mem_to_reg=0.
  - LOAD: reg_dst=0, mem_to_reg=1.
- Latency with mem_ready tied high: R-type 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- mem_req and mem_we stay stable from request start until the mem_ready cycle. mem_ready outside FETCH/MEM is ignored.
- HALT and FAULT are absorbing: no enables asserted, mem_req=0, exit only via reset. halted=1 in HALT only; fault=1 in FAULT only.
- Opcode is sampled combinationally in DECODE/EXECUTE/MEM/WB; the IR must not change outside ir_write.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle that mem_req=1 and mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0, the next state is FAULT and mem_req drops.
  - mem_ready=1 in the same cycle as the limit wins: the transfer completes normally.
- Not defined: no counter; the FSM waits indefinitely for mem_ready.

Test Plan:
- Reset release, mem_ready=1, opcode=0000 → state sequence 0,1,2,3,5,1. alu_op=000 and reg_dst=1 in EXECUTE/WB; reg_write=1 for exactly 1 cycle; ir_write and pc_write pulse once in FETCH.
- opcode=0100 (LOAD), mem_ready low for 3 cycles in MEM → mem_req held 4 cycles with mem_we=0, then WB with mem_to_reg=1, reg_dst=0, reg_write=1. Total 8 cycles FETCH-to-FETCH.
- opcode=0101 (STORE) → MEM with mem_we=1, alu_src=1, then FETCH with reg_write never 1. opcode=0110, zero=1 → pc_write=1, pc_src=1 in EXECUTE; zero=0 → pc_write=0.
- opcode=1111 → HALT, halted=1, mem_req=0 for 20 cycles. opcode=1001 → FAULT, fault=1. Assert rst_n=0 mid-MEM → state=0 and mem_req=0 immediately.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → FAULT after 4 wait cycles. Repeat with mem_ready=1 on the 4th wait cycle → DECODE, no fault.
